multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Control unit for the multicycle MIPS core. It sequences the shared datapath (PC, instruction register, register file, ALU, single unified memory) through fetch, decode, execute, memory and writeback steps, one state per clock. It decodes `op` and `funct` from the instruction register and drives every datapath mux select and write enable. It waits on a memory-ready handshake for every memory access. It sits beside the datapath inside the multicycle `mips` core, which `top` instantiates together with the unified memory.

## Interface

No parameters.

- `clk`  in  1  system clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clk`
- `op`  in  6  instruction[31:26], taken from the instruction register
- `funct`  in  6  instruction[5:0], taken from the instruction register
- `zero`  in  1  ALU zero flag for the current cycle
- `memready`  in  1  memory completes the current access this cycle
- `memwrite`  out  1  memory write strobe
- `irwrite`  out  1  instruction register load
- `regwrite`  out  1  register file write
- `pcen`  out  1  PC load enable
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `memtoreg`  out  1  writeback select: 1 = memory data register
- `regdst`  out  1  destination select: 1 = rd, 0 = rt
- `alusrca`  out  1  ALU A select: 0 = PC, 1 = register A
- `alusrcb`  out  2  ALU B select: 00 = B, 01 = 4, 10 = signimm, 11 = signimm<<2
- `pcsrc`  out  2  PC source select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- `alucontrol`  out  3  ALU function: 010 add, 110 sub, 000 and, 001 or, 111 slt
- `instret`  out  32  count of retired instructions

## Operation

- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX.
- FETCH: `iord`=0, `alusrca`=0, `alusrcb`=01, `pcsrc`=00, ALU add.
  - `irwrite` and `pcwrite` are asserted only when `memready`=1.
  - The FSM stays in FETCH while `memready`=0.
- DECODE: `alusrca`=0, `alusrcb`=11, ALU add (branch target into ALUOut). Next state by `op`:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 -> RTYPEEX
  - 000100 (beq) -> BEQEX
  - 001000 (addi) -> ADDIEX
  - 000010 (j) -> JEX
  - any other opcode -> FETCH; the instruction counts as retired and performs no writes.
- MEMADR: `alusrca`=1, `alusrcb`=10, add. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: `iord`=1. Stays until `memready`=1, then goes to MEMWB.
- MEMWB: `regdst`=0, `memtoreg`=1, `regwrite`=1.
- MEMWR: `iord`=1, `memwrite`=1. Stays until `memready`=1.
- RTYPEEX: `alusrca`=1, `alusrcb`=00. ALU function from `funct`:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt
  - any other funct: ALU add, and the following RTYPEWB suppresses `regwrite`.
- RTYPEWB: `regdst`=1, `memtoreg`=0, `regwrite`=1.
- BEQEX: `alusrca`=1, `alusrcb`=00, sub, `pcsrc`=01, `branch`=1.
- ADDIEX: `alusrca`=1, `alusrcb`=10, add.
- ADDIWB: `regdst`=0, `memtoreg`=0, `regwrite`=1.
- JEX: `pcsrc`=10, `pcwrite`=1.
- Terminal states return to FETCH: MEMWB, MEMWR (after `memready`), RTYPEWB, BEQEX, ADDIWB, JEX.
- `pcen` = `pcwrite` | (`branch` & `zero`), combinational.
- Any output not listed for a state is 0; ALU defaults to add.
- `instret` increments by 1 on each transition from a terminal state (or an illegal DECODE) into FETCH. It wraps from 0xFFFFFFFF to 0.

## Timing

- Reset:
  - On the rising edge with `reset`=1: state <= FETCH, `instret` <= 0.
  - While `reset`=1: `memwrite`, `irwrite`, `regwrite` and `pcen` are forced to 0. All selects show FETCH values.
  - Reset asserted mid-instruction aborts it on that edge; no partial write follows.
- Cycles per instruction with `memready` always 1:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal opcode 2.
- Each cycle `memready`=0 in FETCH, MEMRD or MEMWR adds one cycle. Outputs hold steady while waiting.
- `op`/`funct` are sampled only in DECODE/RTYPEEX; they may change in FETCH without effect.
- Outputs are Moore functions of the state, except these, which are combinational in the same cycle:
  - `pcen` (depends on `zero`)
  - `irwrite` and the FETCH `pcwrite` (depend on `memready`)

## Test plan

- Reset held 3 cycles, then released, `memready`=1, `op`=100011 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. `regwrite`=1 and `memtoreg`=1 only in cycle 5. `instret`=1 after.
- sw with `memready` low for 2 cycles in MEMWR -> `memwrite`=1 and `iord`=1 for 3 consecutive cycles, then FETCH. 6 cycles total.
- R-type sweep over funct 100000/100010/100100/100101/101010 -> `alucontrol` 010/110/000/001/111 in RTYPEEX. funct 000000 -> `regwrite` stays 0 in RTYPEWB.
- beq with `zero`=1 -> `pcen`=1 and `pcsrc`=01 in BEQEX. Same with `zero`=0 -> `pcen`=0. Both take 3 cycles.
- `op`=111111 -> DECODE returns to FETCH with no write strobe. `instret` increments by 1.
- `reset` asserted during MEMWR -> `memwrite`=0 that cycle. Next state FETCH, `instret`=0.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the datapath/memory:
// decode inputs and handshake in, every mux select and write strobe out.
interface multicycle_controller_if;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        memready;
    logic        memwrite;
    logic        irwrite;
    logic        regwrite;
    logic        pcen;
    logic        iord;
    logic        memtoreg;
    logic        regdst;
    logic        alusrca;
    logic [1:0]  alusrcb;
    logic [1:0]  pcsrc;
    logic [2:0]  alucontrol;
    logic [31:0] instret;

    modport master (
        input  op, funct, zero, memready,
        output memwrite, irwrite, regwrite, pcen, iord, memtoreg, regdst,
               alusrca, alusrcb, pcsrc, alucontrol, instret
    );

    modport slave (
        output op, funct, zero, memready,
        input  memwrite, irwrite, regwrite, pcen, iord, memtoreg, regdst,
               alusrca, alusrcb, pcsrc, alucontrol, instret
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: one state per clock, Moore selects, with
// memready-gated fetch strobes and zero-gated branch PC enable.
module multicycle_controller (
    input  logic                          clk,
    input  logic                          reset,
    multicycle_controller_if.master       bus
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t      state, next, cur;
    logic        is_sw;
    logic        funct_ok;
    logic        funct_legal;
    logic [2:0]  funct_alu;
    logic        retire;
    logic [31:0] instret;

    logic        pcwrite, branch;
    logic        memwrite, irwrite, regwrite;
    logic        iord, memtoreg, regdst, alusrca;
    logic [1:0]  alusrcb, pcsrc;
    logic [2:0]  alucontrol;

    // funct decode; unknown functs fall back to add and block the writeback
    always_comb begin
        funct_legal = 1'b1;
        funct_alu   = ALU_ADD;
        case (bus.funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            is_sw    <= 1'b0;
            funct_ok <= 1'b0;
        end else begin
            state <= next;
            if (state == DECODE)  is_sw    <= (bus.op == OP_SW);
            if (state == RTYPEEX) funct_ok <= funct_legal;
        end
    end

    // During reset the selects decode as FETCH; strobes are squashed below
    assign cur = reset ? FETCH : state;

    always_comb begin
        next       = cur;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = ALU_ADD;
        case (cur)
            FETCH: begin
                alusrcb = 2'b01;
                irwrite = bus.memready;
                pcwrite = bus.memready;
                if (bus.memready) next = DECODE;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (bus.op)
                    OP_LW, OP_SW: next = MEMADR;
                    OP_RTYPE:     next = RTYPEEX;
                    OP_BEQ:       next = BEQEX;
                    OP_ADDI:      next = ADDIEX;
                    OP_J:         next = JEX;
                    default:      next = FETCH;
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                next    = is_sw ? MEMWR : MEMRD;
            end
            MEMRD: begin
                iord = 1'b1;
                if (bus.memready) next = MEMWB;
            end
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
                next     = FETCH;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                if (bus.memready) next = FETCH;
            end
            RTYPEEX: begin
                alusrca    = 1'b1;
                alucontrol = funct_alu;
                next       = RTYPEWB;
            end
            RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = funct_ok;
                next     = FETCH;
            end
            BEQEX: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                branch     = 1'b1;
                next       = FETCH;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                next    = ADDIWB;
            end
            ADDIWB: begin
                regwrite = 1'b1;
                next     = FETCH;
            end
            JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                next    = FETCH;
            end
            default: next = FETCH;
        endcase
    end

    // Every exit back to FETCH ends an instruction, including illegal opcodes
    assign retire = (state != FETCH) && (next == FETCH);

    always_ff @(posedge clk) begin
        if (reset)       instret <= 32'd0;
        else if (retire) instret <= instret + 32'd1;
    end

    assign bus.memwrite   = memwrite & ~reset;
    assign bus.irwrite    = irwrite & ~reset;
    assign bus.regwrite   = regwrite & ~reset;
    assign bus.pcen       = (pcwrite | (branch & bus.zero)) & ~reset;
    assign bus.iord       = iord;
    assign bus.memtoreg   = memtoreg;
    assign bus.regdst     = regdst;
    assign bus.alusrca    = alusrca;
    assign bus.alusrcb    = alusrcb;
    assign bus.pcsrc      = pcsrc;
    assign bus.alucontrol = alucontrol;
    assign bus.instret    = instret;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expected control vectors
// queued on drive and compared at the falling edge.
module tb_multicycle_controller;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_controller_if bus ();
    multicycle_controller dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct packed {
        logic        memwrite, irwrite, regwrite, pcen;
        logic        iord, memtoreg, regdst, alusrca;
        logic [1:0]  alusrcb, pcsrc;
        logic [2:0]  alucontrol;
        logic [31:0] instret;
    } obs_t;

    localparam int S_R = 0, S_F = 1, S_D = 2, S_MA = 3, S_MR = 4, S_MWB = 5,
                   S_MW = 6, S_RX = 7, S_RWB = 8, S_BQ = 9, S_AX = 10,
                   S_AWB = 11, S_J = 12;

    obs_t        q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_instret = 32'd0;

    function automatic obs_t expv(int s, logic mr, logic z, logic [2:0] alu, logic rw);
        obs_t e;
        e = '0;
        e.alucontrol = 3'b010;
        e.instret    = exp_instret;
        case (s)
            S_R:   e.alusrcb = 2'b01;
            S_F:   begin e.alusrcb = 2'b01; e.irwrite = mr; e.pcen = mr; end
            S_D:   e.alusrcb = 2'b11;
            S_MA:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            S_MR:  e.iord = 1'b1;
            S_MWB: begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
            S_MW:  begin e.iord = 1'b1; e.memwrite = 1'b1; end
            S_RX:  begin e.alusrca = 1'b1; e.alucontrol = alu; end
            S_RWB: begin e.regdst = 1'b1; e.regwrite = rw; end
            S_BQ:  begin e.alusrca = 1'b1; e.alucontrol = 3'b110; e.pcsrc = 2'b01; e.pcen = z; end
            S_AX:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            S_AWB: e.regwrite = 1'b1;
            S_J:   begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    // Drive one cycle's handshake inputs, queue the expectation, check at negedge
    task automatic step(string tag, int s, logic mr = 1'b1, logic z = 1'b0,
                        logic [2:0] alu = 3'b010, logic rw = 1'b1);
        obs_t got, e;
        bus.memready = mr;
        bus.zero     = z;
        q.push_back(expv(s, mr, z, alu, rw));
        @(negedge clk);
        e   = q.pop_front();
        got = {bus.memwrite, bus.irwrite, bus.regwrite, bus.pcen,
               bus.iord, bus.memtoreg, bus.regdst, bus.alusrca,
               bus.alusrcb, bus.pcsrc, bus.alucontrol, bus.instret};
        n_vec++;
        assert (got === e) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, e);
        end
        @(posedge clk);
        #1;
    endtask

    logic [5:0] fn  [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
    logic [2:0] alx [6] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};

    initial begin
        reset = 1'b1;
        bus.op = 6'b100011;
        bus.funct = 6'b0;
        bus.zero = 1'b0;
        bus.memready = 1'b1;
        @(posedge clk); #1;
        step("rst0", S_R);
        step("rst1", S_R);
        reset = 1'b0;

        // lw, no waits: 5 cycles
        step("lw_f", S_F);
        step("lw_d", S_D);
        bus.op = 6'b000000;  // op is latched by now; changing it must not matter
        step("lw_ma", S_MA);
        step("lw_mr", S_MR);
        step("lw_wb", S_MWB);
        exp_instret++;

        // sw with two wait cycles in MEMWR
        bus.op = 6'b101011;
        step("sw_f", S_F);
        step("sw_d", S_D);
        step("sw_ma", S_MA);
        step("sw_w0", S_MW, 1'b0);
        step("sw_w1", S_MW, 1'b0);
        step("sw_w2", S_MW, 1'b1);
        exp_instret++;

        // fetch stall, then lw with a read stall
        bus.op = 6'b100011;
        step("fst_f0", S_F, 1'b0);
        step("fst_f1", S_F);
        step("lws_d", S_D);
        step("lws_ma", S_MA);
        step("lws_r0", S_MR, 1'b0);
        step("lws_r1", S_MR);
        step("lws_wb", S_MWB);
        exp_instret++;

        // R-type sweep; last entry is an unknown funct
        for (int i = 0; i < 6; i++) begin
            bus.op = 6'b000000;
            bus.funct = fn[i];
            step("r_f", S_F);
            step("r_d", S_D);
            step("r_ex", S_RX, 1'b1, 1'b0, alx[i]);
            step("r_wb", S_RWB, 1'b1, 1'b0, 3'b010, (i < 5));
            exp_instret++;
        end

        // beq taken and not taken
        bus.op = 6'b000100;
        step("bq1_f", S_F);
        step("bq1_d", S_D);
        step("bq1_ex", S_BQ, 1'b1, 1'b1);
        exp_instret++;
        step("bq0_f", S_F);
        step("bq0_d", S_D);
        step("bq0_ex", S_BQ, 1'b1, 1'b0);
        exp_instret++;

        // addi and j
        bus.op = 6'b001000;
        step("ai_f", S_F);
        step("ai_d", S_D);
        step("ai_ex", S_AX);
        step("ai_wb", S_AWB);
        exp_instret++;
        bus.op = 6'b000010;
        step("j_f", S_F);
        step("j_d", S_D);
        step("j_ex", S_J);
        exp_instret++;

        // illegal opcode retires in 2 cycles with no writes
        bus.op = 6'b111111;
        step("ill_f", S_F);
        step("ill_d", S_D);
        exp_instret++;

        // reset while stalled in MEMWR aborts the store
        bus.op = 6'b101011;
        step("ab_f", S_F);
        step("ab_d", S_D);
        step("ab_ma", S_MA);
        step("ab_w0", S_MW, 1'b0);
        reset = 1'b1;
        step("ab_rst", S_R, 1'b0);
        reset = 1'b0;
        exp_instret = 32'd0;
        step("ab_f2", S_F);
        step("ab_d2", S_D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
